// File: rtl/csr_timer_bank.sv
// csr_timer_bank: NUM_CH countdown timers (one-shot/periodic) with pending bits,
// a global interrupt-enable mask and a lowest-index interrupt priority encoder.
module csr_timer_bank #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned CNT_W    = 32,
    parameter logic [13:0] CSR_BASE = 14'h100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [13:0]       csr_num,
    output logic [31:0]       csr_rvalue,
    input  logic              csr_we,
    input  logic [31:0]       csr_wmask,
    input  logic [31:0]       csr_wvalue,
    output logic [NUM_CH-1:0] irq_pend,
    output logic              has_int,
    output logic [2:0]        int_id
);

    localparam int unsigned IV_W    = CNT_W - 2;
    localparam logic [13:0] GLB_OFF = 14'(4 * NUM_CH);

    logic [NUM_CH-1:0]            en_q;
    logic [NUM_CH-1:0]            per_q;
    logic [NUM_CH-1:0][IV_W-1:0]  initv_q;
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q;
    logic [NUM_CH-1:0]            tinten_q;

    logic [13:0] off;
    logic [2:0]  sel_ch;
    logic [1:0]  sel_slot;
    logic        in_ch;
    logic        is_tinten;
    logic        is_tpend;

    logic [NUM_CH-1:0]            tcfg_we;
    logic [NUM_CH-1:0][CNT_W-1:0] tcfg_next;
    logic [NUM_CH-1:0]            pend_clr;
    logic [NUM_CH-1:0]            tinten_next;

    // Address decode relative to the bank base; addresses below the base wrap high and miss
    assign off       = csr_num - CSR_BASE;
    assign sel_ch    = off[4:2];
    assign sel_slot  = off[1:0];
    assign in_ch     = off < GLB_OFF;
    assign is_tinten = off == GLB_OFF;
    assign is_tpend  = off == (GLB_OFF + 14'd1);

    // Read mux: per-channel TCFG/TVAL, global TINTEN/TPEND, zero elsewhere
    always_comb begin
        csr_rvalue = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (in_ch && sel_ch == 3'(i)) begin
                case (sel_slot)
                    2'd0:    csr_rvalue = 32'({initv_q[i], per_q[i], en_q[i]});
                    2'd1:    csr_rvalue = 32'(cnt_q[i]);
                    default: csr_rvalue = '0;
                endcase
            end
        end
        if (is_tinten) csr_rvalue = 32'(tinten_q);
        if (is_tpend)  csr_rvalue = 32'(irq_pend);
    end

    // Write decode and masked merge of register writes
    always_comb begin
        tcfg_we     = '0;
        tcfg_next   = '0;
        pend_clr    = '0;
        tinten_next = (csr_wmask[NUM_CH-1:0] & csr_wvalue[NUM_CH-1:0]) |
                      (~csr_wmask[NUM_CH-1:0] & tinten_q);
        for (int i = 0; i < NUM_CH; i++) begin
            tcfg_next[i] = (csr_wmask[CNT_W-1:0] & csr_wvalue[CNT_W-1:0]) |
                           (~csr_wmask[CNT_W-1:0] & {initv_q[i], per_q[i], en_q[i]});
            if (csr_we && in_ch && sel_ch == 3'(i)) begin
                tcfg_we[i]  = sel_slot == 2'd0;
                pend_clr[i] = (sel_slot == 2'd2) && csr_wmask[0] && csr_wvalue[0];
            end
        end
        if (csr_we && is_tpend)
            pend_clr = pend_clr | (csr_wmask[NUM_CH-1:0] & csr_wvalue[NUM_CH-1:0]);
    end

    // Config, counters and pending bits; a pending set beats a same-cycle clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q     <= '0;
            per_q    <= '0;
            initv_q  <= '0;
            cnt_q    <= '1;
            tinten_q <= '0;
            irq_pend <= '0;
        end else begin
            if (csr_we && is_tinten) tinten_q <= tinten_next;
            for (int i = 0; i < NUM_CH; i++) begin
                if (tcfg_we[i]) begin
                    en_q[i]    <= tcfg_next[i][0];
                    per_q[i]   <= tcfg_next[i][1];
                    initv_q[i] <= tcfg_next[i][CNT_W-1:2];
                end
                if (tcfg_we[i] && tcfg_next[i][0])
                    cnt_q[i] <= {tcfg_next[i][CNT_W-1:2], 2'b00};
                else if (en_q[i] && cnt_q[i] != '1)
                    cnt_q[i] <= (cnt_q[i] == '0 && per_q[i]) ? {initv_q[i], 2'b00}
                                                            : cnt_q[i] - CNT_W'(1);
                if (en_q[i] && cnt_q[i] == '0) irq_pend[i] <= 1'b1;
                else if (pend_clr[i])          irq_pend[i] <= 1'b0;
            end
        end
    end

    // Lowest-index pending-and-enabled channel wins
    always_comb begin
        has_int = |(irq_pend & tinten_q);
        int_id  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (irq_pend[i] && tinten_q[i]) int_id = 3'(i);
        end
    end

endmodule

// File: tb/tb_csr_timer_bank.sv
// Bench for csr_timer_bank: vector table, directed sequences and a random run
// checked against a word-level behavioural model.
module tb_csr_timer_bank;

    localparam logic [13:0] BASE = 14'h100;
    localparam int          NCH  = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [13:0]    csr_num;
    logic [31:0]    csr_rvalue, csr_wmask, csr_wvalue;
    logic           csr_we;
    logic [NCH-1:0] irq_pend;
    logic           has_int;
    logic [2:0]     int_id;

    logic [13:0] num2;
    logic [31:0] rv2, mask2, val2;
    logic        we2;
    logic [1:0]  pend2;
    logic        hi2;
    logic [2:0]  id2;

    csr_timer_bank dut (
        .clk(clk), .reset(reset), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
        .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .irq_pend(irq_pend), .has_int(has_int), .int_id(int_id)
    );

    csr_timer_bank #(.NUM_CH(2), .CNT_W(16), .CSR_BASE(BASE)) dut_w (
        .clk(clk), .reset(reset), .csr_num(num2), .csr_rvalue(rv2),
        .csr_we(we2), .csr_wmask(mask2), .csr_wvalue(val2),
        .irq_pend(pend2), .has_int(hi2), .int_id(id2)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model: each channel keeps its TCFG word and counter as plain 32-bit values
    logic [31:0]    m_cfg [NCH];
    logic [31:0]    m_cnt [NCH];
    logic [NCH-1:0] m_pend, m_ten;

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_cfg[c] = 32'h0;
            m_cnt[c] = 32'hFFFF_FFFF;
        end
        m_pend = '0;
        m_ten  = '0;
    endtask

    function automatic logic [31:0] model_read(logic [13:0] num);
        int off;
        off = int'(num) - int'(BASE);
        if (off < 0) return 32'h0;
        if (off < 4 * NCH) begin
            if (off % 4 == 0) return m_cfg[off / 4];
            if (off % 4 == 1) return m_cnt[off / 4];
            return 32'h0;
        end
        if (off == 4 * NCH)     return 32'(m_ten);
        if (off == 4 * NCH + 1) return 32'(m_pend);
        return 32'h0;
    endfunction

    task automatic model_step();
        logic [31:0]    nc [NCH];
        logic [31:0]    ncfg [NCH];
        logic [NCH-1:0] np, nt;
        logic [31:0]    merged;
        logic           fire, clr;
        int             off;
        off    = int'(csr_num) - int'(BASE);
        merged = (csr_wmask & csr_wvalue) | (~csr_wmask & model_read(csr_num));
        np = m_pend;
        nt = m_ten;
        for (int c = 0; c < NCH; c++) begin
            nc[c]   = m_cnt[c];
            ncfg[c] = m_cfg[c];
            fire = m_cfg[c][0] && m_cnt[c] == 32'h0;
            clr  = csr_we && ((off == 4 * c + 2 && csr_wmask[0] && csr_wvalue[0]) ||
                              (off == 4 * NCH + 1 && csr_wmask[c] && csr_wvalue[c]));
            if (csr_we && off == 4 * c) begin
                ncfg[c] = merged;
                if (merged[0]) nc[c] = merged & ~32'h3;
            end
            if (!(csr_we && off == 4 * c && merged[0]) && m_cfg[c][0] && m_cnt[c] != 32'hFFFF_FFFF) begin
                if (m_cnt[c] == 32'h0 && m_cfg[c][1]) nc[c] = m_cfg[c] & ~32'h3;
                else                                 nc[c] = m_cnt[c] - 32'h1;
            end
            if (fire)     np[c] = 1'b1;
            else if (clr) np[c] = 1'b0;
        end
        if (csr_we && off == 4 * NCH) nt = merged[NCH-1:0];
        for (int c = 0; c < NCH; c++) begin
            m_cnt[c] = nc[c];
            m_cfg[c] = ncfg[c];
        end
        m_pend = np;
        m_ten  = nt;
    endtask

    function automatic logic [2:0] model_id();
        for (int c = 0; c < NCH; c++)
            if (m_pend[c] && m_ten[c]) return 3'(c);
        return 3'd0;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] m, input logic [31:0] v);
        csr_num = a; csr_wmask = m; csr_wvalue = v; csr_we = 1'b1;
        tick();
        csr_we = 1'b0;
    endtask

    task automatic wr2(input logic [13:0] a, input logic [31:0] m, input logic [31:0] v);
        num2 = a; mask2 = m; val2 = v; we2 = 1'b1;
        tick();
        we2 = 1'b0;
    endtask

    task automatic rd(input logic [13:0] a, output logic [31:0] v);
        csr_num = a;
        #1;
        v = csr_rvalue;
    endtask

    task automatic rd2(input logic [13:0] a, output logic [31:0] v);
        num2 = a;
        #1;
        v = rv2;
    endtask

    task automatic do_reset();
        csr_we = 1'b0; we2 = 1'b0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [13:0] num;
        logic [31:0] mask;
        logic [31:0] val;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl [10];
    logic [31:0] r;
    int          t0;

    initial begin
        tbl[0] = '{14'h100, 32'hFFFF_FFFF, 32'h0000_0012, 32'h0000_0012};
        tbl[1] = '{14'h101, 32'hFFFF_FFFF, 32'h0000_1234, 32'hFFFF_FFFF};
        tbl[2] = '{14'h102, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0000};
        tbl[3] = '{14'h103, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[4] = '{14'h104, 32'h0000_FF00, 32'hFFFF_FFFF, 32'h0000_FF00};
        tbl[5] = '{14'h10C, 32'hFFFF_FFFF, 32'h8000_0002, 32'h8000_0002};
        tbl[6] = '{14'h110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_000F};
        tbl[7] = '{14'h110, 32'h0000_0001, 32'h0000_0000, 32'h0000_000E};
        tbl[8] = '{14'h112, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[9] = '{14'h0FF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};

        csr_num = BASE; csr_wmask = '0; csr_wvalue = '0; csr_we = 1'b0;
        num2 = BASE; mask2 = '0; val2 = '0; we2 = 1'b0;
        reset = 1'b1;
        #12;
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset state
        check("rst_pend", 32'(irq_pend), 32'h0);
        check("rst_has_int", 32'(has_int), 32'h0);
        check("rst_int_id", 32'(int_id), 32'h0);
        rd(14'h101, r); check("rst_tval0", r, 32'hFFFF_FFFF);
        rd(14'h100, r); check("rst_tcfg0", r, 32'h0);

        // Address map / masked write table
        for (int i = 0; i < 10; i++) begin
            wr(tbl[i].num, tbl[i].mask, tbl[i].val);
            rd(tbl[i].num, r);
            check($sformatf("tbl[%0d]", i), r, tbl[i].exp);
        end

        // Asynchronous reset in the middle of a count
        do_reset();
        wr(14'h100, 32'hFFFF_FFFF, 32'h0000_0029);
        repeat (20) tick();
        rd(14'h101, r); check("mid_tval0", r, 32'd20);
        #1 reset = 1'b1;
        #1;
        rd(14'h101, r); check("arst_tval0", r, 32'hFFFF_FFFF);
        check("arst_pend", 32'(irq_pend), 32'h0);
        rd(14'h100, r); check("arst_tcfg0", r, 32'h0);
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;

        // One-shot countdown on ch1
        do_reset();
        wr(14'h104, 32'hFFFF_FFFF, 32'h0000_0011);
        for (int k = 16; k >= 0; k--) begin
            rd(14'h105, r); check($sformatf("os_tval=%0d", k), r, 32'(k));
            check("os_no_pend", 32'(irq_pend[1]), 32'h0);
            tick();
        end
        check("os_pend_set", 32'(irq_pend[1]), 32'h1);
        rd(14'h105, r); check("os_tval_ones", r, 32'hFFFF_FFFF);
        repeat (5) tick();
        rd(14'h105, r); check("os_tval_hold", r, 32'hFFFF_FFFF);
        check("os_pend_hold", 32'(irq_pend[1]), 32'h1);
        wr(14'h106, 32'hFFFF_FFFF, 32'h0000_0001);
        check("os_ticlr", 32'(irq_pend[1]), 32'h0);

        // Periodic ch2 with masking
        do_reset();
        wr(14'h108, 32'hFFFF_FFFF, 32'h0000_000B);
        for (int k = 0; k < 30 && !irq_pend[2]; k++) tick();
        check("per_first", 32'(irq_pend[2]), 32'h1);
        check("per_masked", 32'(has_int), 32'h0);
        for (int rep = 0; rep < 2; rep++) begin
            t0 = cyc;
            wr(14'h111, 32'hFFFF_FFFF, 32'h0000_0004);
            check("per_cleared", 32'(irq_pend[2]), 32'h0);
            for (int k = 0; k < 30 && !irq_pend[2]; k++) tick();
            check("per_period", 32'(cyc - t0), 32'd9);
            check("per_masked2", 32'(has_int), 32'h0);
        end
        wr(14'h110, 32'hFFFF_FFFF, 32'h0000_0004);
        check("per_has_int", 32'(has_int), 32'h1);
        check("per_int_id", 32'(int_id), 32'h2);

        // Priority encoder
        do_reset();
        wr(14'h104, 32'hFFFF_FFFF, 32'h0000_0001);
        wr(14'h10C, 32'hFFFF_FFFF, 32'h0000_0001);
        wr(14'h110, 32'hFFFF_FFFF, 32'h0000_000F);
        check("pri_pend", 32'(irq_pend), 32'h0000_000A);
        check("pri_id1", 32'(int_id), 32'h1);
        wr(14'h111, 32'hFFFF_FFFF, 32'h0000_0002);
        check("pri_id3", 32'(int_id), 32'h3);
        check("pri_has3", 32'(has_int), 32'h1);
        wr(14'h111, 32'hFFFF_FFFF, 32'h0000_0008);
        check("pri_none", 32'(has_int), 32'h0);
        check("pri_none_id", 32'(int_id), 32'h0);

        // Set/clear collision, then restart while running
        do_reset();
        wr(14'h100, 32'hFFFF_FFFF, 32'h0000_0001);
        wr(14'h102, 32'hFFFF_FFFF, 32'h0000_0001);
        check("coll_set_wins", 32'(irq_pend[0]), 32'h1);
        wr(14'h102, 32'hFFFF_FFFF, 32'h0000_0001);
        check("coll_cleared", 32'(irq_pend[0]), 32'h0);
        wr(14'h100, 32'hFFFF_FFFF, 32'h0000_0029);
        repeat (5) tick();
        rd(14'h101, r); check("rs_before", r, 32'd35);
        wr(14'h100, 32'h0000_0003, 32'h0000_0001);
        rd(14'h101, r); check("rs_reload", r, 32'd40);
        rd(14'h100, r); check("rs_tcfg", r, 32'h0000_0029);
        tick();
        rd(14'h101, r); check("rs_run", r, 32'd39);

        // Narrow instance: CNT_W=16, NUM_CH=2
        do_reset();
        wr2(14'h100, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        rd2(14'h100, r); check("w_tcfg", r, 32'h0000_FFFD);
        rd2(14'h101, r); check("w_tval", r, 32'h0000_FFFC);
        wr2(14'h108, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd2(14'h108, r); check("w_tinten", r, 32'h0000_0003);
        rd2(14'h109, r); check("w_tpend_hi", r & ~32'h3, 32'h0);
        wr2(14'h10A, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd2(14'h10A, r); check("w_unmapped", r, 32'h0);

        // Randomized run against the model
        do_reset();
        for (int n = 0; n < 800; n++) begin
            int o;
            o = $urandom_range(0, 19) - 1;
            csr_num = 14'(int'(BASE) + o);
            csr_we  = ($urandom_range(0, 9) < 4);
            csr_wmask = ($urandom_range(0, 3) == 0) ? $urandom() : 32'hFFFF_FFFF;
            if (o >= 0 && o < 16 && o % 4 == 0) csr_wvalue = 32'($urandom_range(0, 63));
            else                                csr_wvalue = $urandom();
            #1;
            check("rnd_rvalue", csr_rvalue, model_read(csr_num));
            check("rnd_pend", 32'(irq_pend), 32'(m_pend));
            check("rnd_has_int", 32'(has_int), 32'(|(m_pend & m_ten)));
            check("rnd_int_id", 32'(int_id), 32'(model_id()));
            tick();
            csr_we = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
